// File: rtl/keypad_note_player_pkg.sv
// Shared definitions for the keypad note player: key codes, FSM states,
// the note frequency table and the tone half-period calculation.
package keypad_pkg;

  localparam logic [3:0] NO_KEY = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED
  } state_t;

  // Keys 1..8 map onto C4..C5 of the C-major scale.
  function automatic logic is_tone_key(input logic [3:0] code);
    return (code >= 4'd1) && (code <= 4'd8);
  endfunction

  // Note frequency table in Hz, indexed by key code; 0 for silent keys.
  function automatic int unsigned note_hz(input logic [3:0] code);
    case (code)
      4'd1:    return 262;
      4'd2:    return 294;
      4'd3:    return 330;
      4'd4:    return 349;
      4'd5:    return 392;
      4'd6:    return 440;
      4'd7:    return 494;
      4'd8:    return 523;
      default: return 0;
    endcase
  endfunction

  // Clock cycles per half wave of the note; 0 marks a silent key.
  // Only evaluated on constants, so no divider is ever built.
  function automatic logic [19:0] half_period(input int unsigned clk_hz,
                                              input logic [3:0]  code);
    if (!is_tone_key(code)) return 20'd0;
    return 20'(clk_hz / (32'd2 * note_hz(code)));
  endfunction

endpackage

// File: rtl/keypad_note_player_tone_divider.sv
// Square-wave generator: toggles the output every half_period cycles while
// enabled, and holds count and output at zero whenever disabled.
module tone_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [19:0] half_period,
  output logic        tone
);

  logic [19:0] half_cnt;

  // Half-period counter; the output flips each time the count wraps.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      half_cnt <= '0;
      tone     <= 1'b0;
    end else if (half_cnt == half_period - 20'd1) begin
      half_cnt <= '0;
      tone     <= ~tone;
    end else begin
      half_cnt <= half_cnt + 20'd1;
    end
  end

endmodule

// File: rtl/keypad_note_player.sv
// Keypad note player: synchronizes and debounces the scanner key code,
// reports press events and held keys, and drives a buzzer tone for keys 1..8.
module keypad_note_player
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 200_000,
  parameter int unsigned RELEASE_CYCLES  = 400_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] code_in,
  output logic       key_pulse,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       note_active,
  output logic       tone_out
);

  localparam int unsigned STAB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned GAP_W  = $clog2(RELEASE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(RELEASE_CYCLES);

  localparam logic [19:0] HP_1 = half_period(CLK_HZ, 4'd1);
  localparam logic [19:0] HP_2 = half_period(CLK_HZ, 4'd2);
  localparam logic [19:0] HP_3 = half_period(CLK_HZ, 4'd3);
  localparam logic [19:0] HP_4 = half_period(CLK_HZ, 4'd4);
  localparam logic [19:0] HP_5 = half_period(CLK_HZ, 4'd5);
  localparam logic [19:0] HP_6 = half_period(CLK_HZ, 4'd6);
  localparam logic [19:0] HP_7 = half_period(CLK_HZ, 4'd7);
  localparam logic [19:0] HP_8 = half_period(CLK_HZ, 4'd8);

  logic [3:0]        code_p0;
  logic [3:0]        code_p1;
  state_t            state;
  logic [3:0]        cand;
  logic [STAB_W-1:0] stab_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [19:0]       hp;
  logic              tone_en;

  // Two-flop synchronizer; code_p1 is the sample the FSM acts on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_p0 <= NO_KEY;
      code_p1 <= NO_KEY;
    end else begin
      code_p0 <= code_in;
      code_p1 <= code_p0;
    end
  end

  // Debounce/press/release FSM with registered key outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cand        <= NO_KEY;
      stab_cnt    <= '0;
      gap_cnt     <= '0;
      key_pulse   <= 1'b0;
      key_valid   <= 1'b0;
      key_code    <= NO_KEY;
      note_active <= 1'b0;
    end else begin
      key_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (code_p1 != NO_KEY) begin
            cand     <= code_p1;
            stab_cnt <= STAB_ONE;
            gap_cnt  <= '0;
            state    <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (code_p1 != NO_KEY && code_p1 != cand) begin
            // A different key restarts the stability count.
            cand     <= code_p1;
            stab_cnt <= STAB_ONE;
            gap_cnt  <= '0;
          end else if (gap_cnt == GAP_MAX) begin
            state    <= IDLE;
            stab_cnt <= '0;
            gap_cnt  <= '0;
          end else begin
            // Scanner gaps (F) pause the stability count but extend the gap run.
            gap_cnt <= (code_p1 == NO_KEY) ? gap_cnt + 1'b1 : '0;
            if (stab_cnt == STAB_MAX) begin
              state       <= PRESSED;
              stab_cnt    <= '0;
              key_pulse   <= 1'b1;
              key_valid   <= 1'b1;
              key_code    <= cand;
              note_active <= is_tone_key(cand);
            end else if (code_p1 == cand) begin
              stab_cnt <= stab_cnt + 1'b1;
            end
          end
        end
        PRESSED: begin
          if (gap_cnt == GAP_MAX) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            key_valid   <= 1'b0;
            key_code    <= NO_KEY;
            note_active <= 1'b0;
          end else if (code_p1 == NO_KEY) begin
            gap_cnt <= gap_cnt + 1'b1;
          end else if (code_p1 == cand) begin
            gap_cnt <= '0;
          end
          // Any other key is ignored and leaves the gap run untouched.
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Half-period lookup for the accepted key; silent keys never enable the divider.
  always_comb begin
    hp = 20'd0;
    case (key_code)
      4'd1:    hp = HP_1;
      4'd2:    hp = HP_2;
      4'd3:    hp = HP_3;
      4'd4:    hp = HP_4;
      4'd5:    hp = HP_5;
      4'd6:    hp = HP_6;
      4'd7:    hp = HP_7;
      4'd8:    hp = HP_8;
      default: hp = 20'd0;
    endcase
  end

  // Drop the enable on the release edge itself so the tone stops with key_valid.
  assign tone_en = note_active && (gap_cnt != GAP_MAX);

  tone_divider u_tone_divider (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (tone_en),
    .half_period (hp),
    .tone        (tone_out)
  );

endmodule

// File: tb/tb_keypad_note_player.sv
// Bench for keypad_note_player: press events are scored against a queue of
// expected (cycle, code) entries; levels and tone timing are checked inline.
`timescale 1ns/1ps
module tb_keypad_note_player;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned DEB    = 8;
  localparam int unsigned REL    = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] code_in = 4'hF;
  logic       key_pulse, key_valid, note_active, tone_out;
  logic [3:0] key_code;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         at;
    logic [3:0] code;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  keypad_note_player #(
    .CLK_HZ          (CLK_HZ),
    .DEBOUNCE_CYCLES (DEB),
    .RELEASE_CYCLES  (REL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .code_in     (code_in),
    .key_pulse   (key_pulse),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .note_active (note_active),
    .tone_out    (tone_out)
  );

  always #5 clk = ~clk;

  // Count rising edges; at a falling edge cyc equals the edge just taken.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every key_pulse must match the oldest expected press.
  always @(negedge clk) begin
    if (sb.size() > 0 && cyc > sb[0].at) begin
      checks++; failures++;
      $display("FAIL pulse_missing: no pulse by cycle %0d, required at cycle %0d code %0d",
               cyc, sb[0].at, sb[0].code);
      void'(sb.pop_front());
    end
    if (key_pulse === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL pulse_unexpected: pulse at cycle %0d code %0d, required none", cyc, key_code);
      end else begin
        mon_e = sb.pop_front();
        if (cyc != mon_e.at || key_code !== mon_e.code) begin
          failures++;
          $display("FAIL pulse_match: got cycle %0d code %0d, required cycle %0d code %0d",
                   cyc, key_code, mon_e.at, mon_e.code);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input int at, input logic [3:0] code);
    exp_t e;
    e.at   = at;
    e.code = code;
    sb.push_back(e);
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; code_in = 4'hF;
    repeat (3) @(negedge clk);
    checks++; if (key_pulse !== 1'b0)   begin failures++; $display("FAIL reset_pulse: got %b, required 0", key_pulse); end
    checks++; if (key_valid !== 1'b0)   begin failures++; $display("FAIL reset_valid: got %b, required 0", key_valid); end
    checks++; if (key_code !== 4'hF)    begin failures++; $display("FAIL reset_code: got %h, required f", key_code); end
    checks++; if (note_active !== 1'b0) begin failures++; $display("FAIL reset_note: got %b, required 0", note_active); end
    checks++; if (tone_out !== 1'b0)    begin failures++; $display("FAIL reset_tone: got %b, required 0", tone_out); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Key 1 held 40 cycles: pulse 8 edges after capture (capture = drive + 3).
  task automatic test_clean_press;
    int k;
    k = cyc; code_in = 4'd1; push_exp(k + 11, 4'd1);
    goto_cyc(k + 10);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL clean_early_valid: got %b, required 0", key_valid); end
    goto_cyc(k + 11);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd1 || note_active !== 1'b1 || tone_out !== 1'b0) begin
      failures++; $display("FAIL clean_accept: valid=%b code=%h note=%b tone=%b, required 1 1 1 0",
                           key_valid, key_code, note_active, tone_out);
    end
    for (int c = k + 12; c <= k + 40; c++) begin
      goto_cyc(c);
      checks++; if (key_valid !== 1'b1 || key_code !== 4'd1 || tone_out !== 1'b0) begin
        failures++; $display("FAIL clean_hold cycle %0d: valid=%b code=%h tone=%b, required 1 1 0",
                             c, key_valid, key_code, tone_out);
      end
    end
    code_in = 4'hF;
    goto_cyc(k + 48);
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL clean_early_release: got %b, required 1", key_valid); end
    goto_cyc(k + 49);
    checks++; if (key_valid !== 1'b0 || key_code !== 4'hF || note_active !== 1'b0 || tone_out !== 1'b0) begin
      failures++; $display("FAIL clean_release: valid=%b code=%h note=%b tone=%b, required 0 f 0 0",
                           key_valid, key_code, note_active, tone_out);
    end
    repeat (5) @(negedge clk);
  endtask

  // Key 5 for 1 cycle, F for 3, ten times: stability only counts key-5 samples.
  task automatic test_scanner_gaps;
    int j;
    j = cyc; push_exp(j + 32, 4'd5);
    for (int t = 0; t <= 48; t++) begin
      goto_cyc(j + t);
      if (t >= 32 && t <= 45) begin
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd5) begin
          failures++; $display("FAIL gaps_hold t=%0d: valid=%b code=%h, required 1 5", t, key_valid, key_code);
        end
      end
      if (t == 46) begin
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL gaps_release: got %b, required 0", key_valid); end
      end
      code_in = (t < 40 && (t % 4) == 0) ? 4'd5 : 4'hF;
    end
    repeat (5) @(negedge clk);
  endtask

  // 2,3,2,3 then steady 3: one press, 8 edges after the last restart.
  task automatic test_bounce;
    int j;
    j = cyc; push_exp(j + 14, 4'd3);
    for (int t = 0; t <= 20; t++) begin
      goto_cyc(j + t);
      if (t == 13) begin
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL bounce_early: got %b, required 0", key_valid); end
      end
      if (t == 14) begin
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd3) begin
          failures++; $display("FAIL bounce_accept: valid=%b code=%h, required 1 3", key_valid, key_code);
        end
      end
      code_in = (t == 0 || t == 2) ? 4'd2 : ((t < 20) ? 4'd3 : 4'hF);
    end
    goto_cyc(j + 30);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL bounce_release: got %b, required 0", key_valid); end
    repeat (5) @(negedge clk);
  endtask

  // Key 7 for 4 cycles: no press; FSM idles after 6 F samples, so a fresh 7
  // arriving afterwards is debounced from scratch.
  task automatic test_glitch;
    int j;
    j = cyc; push_exp(j + 23, 4'd7);
    for (int t = 0; t <= 30; t++) begin
      goto_cyc(j + t);
      if (t == 22) begin
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL glitch_early: got %b, required 0", key_valid); end
      end
      if (t == 23) begin
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd7) begin
          failures++; $display("FAIL glitch_fresh: valid=%b code=%h, required 1 7", key_valid, key_code);
        end
      end
      code_in = (t < 4 || (t >= 12 && t < 30)) ? 4'd7 : 4'hF;
    end
    goto_cyc(j + 40);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL glitch_release: got %b, required 0", key_valid); end
    repeat (5) @(negedge clk);
  endtask

  // '#' is accepted but silent; key 8 has HP = 1e6/(2*523) = 956.
  task automatic test_silent_and_tone;
    int j, k, p;
    j = cyc; push_exp(j + 11, 4'd11);
    for (int t = 0; t <= 35; t++) begin
      goto_cyc(j + t);
      if (t >= 11 && t <= 28) begin
        checks++; if (key_valid !== 1'b1 || note_active !== 1'b0 || tone_out !== 1'b0) begin
          failures++; $display("FAIL silent_hold t=%0d: valid=%b note=%b tone=%b, required 1 0 0",
                               t, key_valid, note_active, tone_out);
        end
      end
      if (t == 29) begin
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL silent_release: got %b, required 0", key_valid); end
      end
      code_in = (t < 20) ? 4'd11 : 4'hF;
    end
    k = cyc; code_in = 4'd8; push_exp(k + 11, 4'd8); p = k + 11;
    goto_cyc(p);
    checks++; if (note_active !== 1'b1 || tone_out !== 1'b0) begin
      failures++; $display("FAIL tone_entry: note=%b tone=%b, required 1 0", note_active, tone_out);
    end
    goto_cyc(p + 955);
    checks++; if (tone_out !== 1'b0) begin failures++; $display("FAIL tone_pre_rise: got %b, required 0", tone_out); end
    goto_cyc(p + 956);
    checks++; if (tone_out !== 1'b1) begin failures++; $display("FAIL tone_first_rise: got %b, required 1", tone_out); end
    goto_cyc(p + 1911);
    checks++; if (tone_out !== 1'b1) begin failures++; $display("FAIL tone_high_end: got %b, required 1", tone_out); end
    goto_cyc(p + 1912);
    checks++; if (tone_out !== 1'b0) begin failures++; $display("FAIL tone_fall: got %b, required 0", tone_out); end
    goto_cyc(p + 2867);
    checks++; if (tone_out !== 1'b0) begin failures++; $display("FAIL tone_low_end: got %b, required 0", tone_out); end
    goto_cyc(p + 2868);
    checks++; if (tone_out !== 1'b1) begin failures++; $display("FAIL tone_second_rise: got %b, required 1", tone_out); end
    code_in = 4'hF;
    goto_cyc(p + 2868 + 12);
    checks++; if (key_valid !== 1'b0 || note_active !== 1'b0 || tone_out !== 1'b0) begin
      failures++; $display("FAIL tone_release: valid=%b note=%b tone=%b, required 0 0 0",
                           key_valid, note_active, tone_out);
    end
    repeat (5) @(negedge clk);
  endtask

  // Reset while key 4 (HP = 1432) is toning high, key still held.
  task automatic test_reset_mid_press;
    int k, p, r;
    k = cyc; code_in = 4'd4; push_exp(k + 11, 4'd4); p = k + 11;
    goto_cyc(p + 1432);
    checks++; if (tone_out !== 1'b1) begin failures++; $display("FAIL rstmid_tone_before: got %b, required 1", tone_out); end
    goto_cyc(p + 1440);
    r = cyc; rst_n = 1'b0;
    goto_cyc(r + 1);
    checks++; if (key_pulse !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'hF ||
                  note_active !== 1'b0 || tone_out !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs: pulse=%b valid=%b code=%h note=%b tone=%b, required 0 0 f 0 0",
                           key_pulse, key_valid, key_code, note_active, tone_out);
    end
    rst_n = 1'b1; push_exp(r + 12, 4'd4);
    goto_cyc(r + 11);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rstmid_early: got %b, required 0", key_valid); end
    goto_cyc(r + 12);
    checks++; if (key_valid !== 1'b1 || note_active !== 1'b1 || tone_out !== 1'b0) begin
      failures++; $display("FAIL rstmid_reaccept: valid=%b note=%b tone=%b, required 1 1 0",
                           key_valid, note_active, tone_out);
    end
    goto_cyc(r + 12 + 1431);
    checks++; if (tone_out !== 1'b0) begin failures++; $display("FAIL rstmid_pre_rise: got %b, required 0", tone_out); end
    goto_cyc(r + 12 + 1432);
    checks++; if (tone_out !== 1'b1) begin failures++; $display("FAIL rstmid_rise: got %b, required 1", tone_out); end
    code_in = 4'hF;
    goto_cyc(r + 12 + 1432 + 12);
    checks++; if (key_valid !== 1'b0 || tone_out !== 1'b0) begin
      failures++; $display("FAIL rstmid_release: valid=%b tone=%b, required 0 0", key_valid, tone_out);
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_scanner_gaps();
    test_bounce();
    test_glitch();
    test_silent_and_tone();
    test_reset_mid_press();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d presses outstanding, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
